// File: rtl/saturation_timer.sv
// Down-counting phase timer: loads while down=0, decrements while down=1, saturates at zero.
// Optional one-cycle expiry pulse output enabled by defining SATURATION_TIMER_EXPIRE_EN.
module saturation_timer #(
  parameter int unsigned BIT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 down,
  input  logic [BIT_WIDTH-1:0] loadIn,
  output logic [BIT_WIDTH-1:0] currentCount,
`ifdef SATURATION_TIMER_EXPIRE_EN
  output logic                 expired,
`endif
  output logic                 isZero
);

  logic [BIT_WIDTH-1:0] count_d, count_q;
  logic                 count_is_zero;
  logic                 count_is_one;

  assign count_is_zero = (count_q == '0);
  assign count_is_one  = (count_q == BIT_WIDTH'(1));

  always_comb begin
    count_d = count_q;
    if (reset) begin
      count_d = '0;
    end else if (!down) begin
      count_d = loadIn;
    end else if (!count_is_zero) begin
      count_d = count_q - BIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign currentCount = count_q;
  assign isZero       = count_is_zero;

`ifdef SATURATION_TIMER_EXPIRE_EN
  logic expired_d, expired_q;

  // Only a real 1->0 decrement counts as expiry; loads of zero and saturated holds do not.
  always_comb begin
    expired_d = 1'b0;
    if (!reset && down && count_is_one) begin
      expired_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      expired_q <= 1'b0;
    end else begin
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;
`endif

endmodule

// File: tb/tb_saturation_timer.sv
// Self-checking bench for saturation_timer: directed scenarios then randomized stimulus
// against an integer reference model. Define SATURATION_TIMER_EXPIRE_EN to also check expired.
module tb_saturation_timer;

  localparam int unsigned W = 6;

  logic         clk;
  logic         reset;
  logic         down;
  logic [W-1:0] loadIn;
  logic [W-1:0] currentCount;
  logic         isZero;
`ifdef SATURATION_TIMER_EXPIRE_EN
  logic         expired;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: plain integers following the load/decrement/saturate rules.
  int model_count = 0;
  int model_expired = 0;

  saturation_timer #(
    .BIT_WIDTH(W)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .down        (down),
    .loadIn      (loadIn),
    .currentCount(currentCount),
`ifdef SATURATION_TIMER_EXPIRE_EN
    .expired     (expired),
`endif
    .isZero      (isZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic d, input logic [W-1:0] l);
    reset  = r;
    down   = d;
    loadIn = l;
    @(posedge clk);
    model_expired = 0;
    if (r) begin
      model_count = 0;
    end else if (!d) begin
      model_count = int'(l);
    end else if (model_count > 0) begin
      model_count = model_count - 1;
      if (model_count == 0) model_expired = 1;
    end
    #1;
    check("count", 32'(currentCount), 32'(model_count));
    check("isZero", 32'(isZero), 32'(model_count == 0));
`ifdef SATURATION_TIMER_EXPIRE_EN
    check("expired", 32'(expired), 32'(model_expired));
`endif
  endtask

  initial begin
    reset  = 1'b1;
    down   = 1'b1;
    loadIn = 6'd37;

    // Reset for two edges with arbitrary inputs
    step(1'b1, 1'b1, 6'd37);
    step(1'b1, 1'b0, 6'd21);

    // Load 10, count down to zero
    step(1'b0, 1'b0, 6'd10);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 6'($urandom_range(0, 63)));

    // Saturation hold
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 6'($urandom_range(0, 63)));

    // Max load, ignored loadIn while counting, reload
    step(1'b0, 1'b0, 6'd63);
    step(1'b0, 1'b1, 6'd31);
    step(1'b0, 1'b1, 6'd15);
    step(1'b0, 1'b0, 6'd15);

    // Reset mid-count
    step(1'b0, 1'b0, 6'd12);
    step(1'b1, 1'b1, 6'd12);
    step(1'b0, 1'b1, 6'd12);

    // Zero load then hold
    step(1'b0, 1'b0, 6'd5);
    step(1'b0, 1'b0, 6'd0);
    step(1'b0, 1'b1, 6'd0);
    step(1'b0, 1'b1, 6'd44);

    // Randomized: short loads so expiry and saturation occur often
    for (int i = 0; i < 600; i++) begin
      logic r, d;
      logic [W-1:0] l;
      r = ($urandom_range(0, 39) == 0);
      d = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 4));
      step(r, d, l);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
